// File: rtl/fmul_issue_ctrl.sv
// Issue/writeback sequencer for a LATENCY-stage FP-multiply pipeline with a destination scoreboard.
// Optional flush port and logic are built only when FMUL_FLUSH_EN is defined.
module fmul_issue_ctrl #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    output logic        pipe_en,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] rd_pending,
    output logic [2:0]  inflight_cnt,
    output logic        busy
`ifdef FMUL_FLUSH_EN
    ,
    input  logic        flush
`endif
);

    // Handshakes: an op transfers on req_valid && req_ready, a result on
    // wb_valid && wb_ready; neither valid ever waits on its own ready.
    logic [LATENCY-1:0]      valid_q, valid_d;
    logic [LATENCY-1:0][4:0] rd_q, rd_d;
    logic [31:0]             pending_q, pending_d;
    logic [2:0]              cnt_q, cnt_d;

    logic stall;
    logic accept;
    logic wb_fire;
    logic flush_w;
    logic rd_hazard;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

`ifdef FMUL_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign stall     = valid_q[LATENCY-1] & ~wb_ready;
    assign pipe_en   = ~stall;
    assign rd_hazard = (req_rd != 5'd0) & pending_q[req_rd];
    assign req_ready = ~stall & ~rd_hazard & ~flush_w;
    assign accept    = req_valid & req_ready;

    assign wb_valid     = valid_q[LATENCY-1];
    assign wb_rd        = rd_q[LATENCY-1];
    assign wb_fire      = wb_valid & wb_ready;
    assign rd_pending   = pending_q;
    assign inflight_cnt = cnt_q;
    assign busy         = (cnt_q != 3'd0);

    // rd=0 ops occupy pipeline slots but never own a scoreboard bit.
    assign set_mask = (accept && req_rd != 5'd0) ? (32'd1 << req_rd) : 32'd0;
    assign clr_mask = wb_fire ? (32'd1 << wb_rd) : 32'd0;

    always_comb begin
        valid_d   = valid_q;
        rd_d      = rd_q;
        pending_d = (pending_q & ~clr_mask) | set_mask;
        cnt_d     = cnt_q;

        if (pipe_en) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                rd_d[i]    = rd_q[i-1];
            end
            valid_d[0] = accept;
            rd_d[0]    = accept ? req_rd : rd_q[0];
        end

        if (accept && !wb_fire) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!accept && wb_fire) begin
            cnt_d = cnt_q - 3'd1;
        end

        // Flush wins over stall: nothing survives, and no accept happens.
        if (flush_w) begin
            valid_d   = '0;
            pending_d = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            rd_q      <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: doc/fmul_issue_ctrl.md
FMUL_ISSUE_CTRL -- requirements
Module: fmul_issue_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning the number of FP-multiply pipeline stages sequenced (legal range 2..7).
REQ-002 The block SHALL have port clk, input, 1, meaning clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1, meaning the issue stage presents an FMUL op.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the op is accepted this cycle.
REQ-006 The block SHALL have port req_rd, input, 5, meaning the op's destination register tag.
REQ-007 The block SHALL have port pipe_en, output, 1, meaning the advance enable driven to every FP-multiply stage register.
REQ-008 The block SHALL have port wb_valid, output, 1, meaning the final stage holds a result for writeback.
REQ-009 The block SHALL have port wb_ready, input, 1, meaning the FP register file accepts the writeback.
REQ-010 The block SHALL have port wb_rd, output, 5, meaning the destination tag of the final-stage result.
REQ-011 The block SHALL have port rd_pending, output, 32, meaning the scoreboard bit per register with an in-flight write.
REQ-012 The block SHALL have port inflight_cnt, output, 3, meaning the number of valid ops in the pipeline.
REQ-013 The block SHALL have port busy, output, 1, meaning inflight_cnt is nonzero.
REQ-014 The block SHALL have port flush, input, 1, meaning kill all in-flight ops; this port exists only per REQ-032.

Function
REQ-015 The block SHALL hold a LATENCY-deep shift register of {valid, rd} entries, with entry 0 loaded on accept and entry LATENCY-1 being the final stage.
REQ-016 The block SHALL compute stall = valid[LATENCY-1] AND NOT wb_ready, and drive pipe_en = NOT stall combinationally.
REQ-017 The block SHALL shift all entries by one position when pipe_en=1 and hold every entry unchanged when pipe_en=0.
REQ-018 The block SHALL drive req_ready = NOT stall AND NOT (req_rd != 0 AND rd_pending[req_rd]) AND NOT flush.
REQ-019 The block SHALL load entry 0 with {1, req_rd} on a shift when req_valid AND req_ready, and with {0, previous rd} on a shift otherwise.
REQ-020 The block SHALL drive wb_valid = valid[LATENCY-1] and wb_rd = rd[LATENCY-1], and a writeback completes when wb_valid AND wb_ready.
REQ-021 The block SHALL give a result accepted with no stall the fixed latency of LATENCY cycles from accept to the first wb_valid cycle.
REQ-022 The block SHALL set rd_pending[req_rd] on accept when req_rd != 0 and SHALL never set bit 0.
REQ-023 The block SHALL clear rd_pending[wb_rd] on writeback completion.
REQ-024 The block SHALL leave a bit set when it is cleared by writeback and set by accept in the same cycle, the set having priority.
REQ-025 The block SHALL track ops with rd=0 in the pipeline and count them in inflight_cnt, while never setting their scoreboard bit.
REQ-026 The block SHALL update inflight_cnt by +1 on accept only, -1 on writeback only, and unchanged on both or neither.
REQ-027 The block SHALL not overflow inflight_cnt, since the count never exceeds LATENCY.
REQ-028 The block SHALL keep wb_valid, wb_rd and every pipeline entry stable while stall=1, with back-to-back accepts allowed only when stall=0.

Reset
REQ-029 The block SHALL on rst clear all valid bits, rd fields, rd_pending and inflight_cnt to 0 immediately, asynchronously to clk.
REQ-030 The block SHALL while in reset drive wb_valid=0, busy=0 and pipe_en=1, with req_ready following REQ-018 and equal to 1 for any req_rd.
REQ-031 The block SHALL discard in-flight ops when reset is asserted mid-operation, with no writeback issued for them after reset release.

Configuration
REQ-032 The block SHALL include the flush port and flush logic when FMUL_FLUSH_EN is defined, and omit them when it is not.
REQ-033 The block SHALL with FMUL_FLUSH_EN defined, on a flush=1 edge, clear all valid bits, rd_pending and inflight_cnt regardless of stall, take no accept that cycle, and drive wb_valid=0 from the next cycle.
REQ-034 The block SHALL with FMUL_FLUSH_EN undefined have no flush port, and REQ-018 SHALL omit the flush term.

Verification
REQ-035 The bench SHALL cover single op: rd=5 accepted at cycle 0, wb_ready=1 -> wb_valid=1 with wb_rd=5 at cycle 4, rd_pending[5] set during cycles 1..4 and 0 from cycle 5.
REQ-036 The bench SHALL cover a burst: rd=1,2,3,4 on consecutive cycles, wb_ready=1 -> writebacks 1,2,3,4 on cycles 4..7, with inflight_cnt peaking at 4.
REQ-037 The bench SHALL cover backpressure: wb_ready=0 for 3 cycles while the final stage is valid -> pipe_en=0, req_ready=0 and wb_rd held, with the pipeline resuming the cycle wb_ready=1.
REQ-038 The bench SHALL cover a WAW hazard: rd=7 in flight and a new req_rd=7 -> req_ready=0 until the writeback cycle of rd=7, with accept the following cycle.
REQ-039 The bench SHALL cover rd=0: three ops with rd=0 -> rd_pending stays 0 and the three writebacks occur with inflight_cnt returning to 0.
REQ-040 The bench SHALL cover reset/flush mid-operation: rst (or flush with FMUL_FLUSH_EN) with 3 ops in flight -> wb_valid=0, rd_pending=0 and inflight_cnt=0 the next cycle, with no stale writeback.
